sign_two: RTL and testbench

SIGN_TWO -- requirements
Module: sign_two

---
 rtl/sign_two.sv | 121 ++++++++++++
 tb/tb_sign_two.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_two.sv
// Bit-serial sign-magnitude to two's-complement converter.
// LSB first, one bit per clock, using a single half-adder carry stage.
module sign_two #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] din,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] dout,
    output logic         neg_zero
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    logic [N-1:0]   r_operand;
    logic [N-1:0]   r_result;
    logic [CW-1:0]  r_cnt;
    logic           r_sign;
    logic           r_carry;
    logic [N-1:0]   r_dout;
    logic           r_neg_zero;

    logic           w_last;
    logic           w_b;
    logic           w_a;
    logic           w_res_bit;
    logic [N-1:0]   w_result_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The sign bit position contributes a zero operand bit, so the result MSB
    // comes purely from sign and carry.
    always_comb begin
        w_last        = (r_cnt == LAST);
        w_b           = w_last ? 1'b0 : r_operand[r_cnt];
        w_a           = w_b ^ r_sign;
        w_res_bit     = w_a ^ r_carry;
        w_result_next = {w_res_bit, r_result[N-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_operand  <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_carry    <= 1'b0;
            r_dout     <= '0;
            r_neg_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_operand <= din;
                        r_sign    <= din[N-1];
                        r_carry   <= din[N-1];
                        r_cnt     <= '0;
                    end
                end
                S_SHIFT: begin
                    r_result <= w_result_next;
                    r_carry  <= w_a & r_carry;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_dout     <= w_result_next;
                        r_neg_zero <= r_sign & (r_operand[N-2:0] == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign neg_zero = r_neg_zero;

endmodule

// File: tb/tb_sign_two.sv
// Self-checking bench for sign_two (N=8): scoreboard of expected results
// built from the sign-magnitude definition, compared when done pulses.
`timescale 1ns/1ps
module tb_sign_two;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] din;
    logic         busy;
    logic         done;
    logic [N-1:0] dout;
    logic         neg_zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [N:0] exp_q[$];

    sign_two #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .neg_zero (neg_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected {neg_zero, dout} from the arithmetic definition.
    function automatic logic [N:0] model(input logic [N-1:0] d);
        logic [N-1:0] m;
        logic [N-1:0] r;
        m = {1'b0, d[N-2:0]};
        r = d[N-1] ? (~m + 1'b1) : m;
        return {d[N-1] && (d[N-2:0] == '0), r};
    endfunction

    task automatic start_conv(input logic [N-1:0] d, input bit push);
        start = 1'b1;
        din   = d;
        tick();
        start = 1'b0;
        if (push) exp_q.push_back(model(d));
    endtask

    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 50) begin
            if (busy) busy_cnt++;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        logic [N:0] e;
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (2) tick();
        checks++;
        if ({busy, done, neg_zero, dout} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b nz=%b dout=%h, required all 0",
                     busy, done, neg_zero, dout);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
        $display("reset: busy=%b done=%b dout=%h nz=%b", busy, done, dout, neg_zero);
    endtask

    task automatic test_positive();
        int cycles, bcnt;
        logic [N:0] e;
        start_conv(8'h05, 1'b1);
        wait_done(cycles, bcnt);
        e = exp_q.pop_front();
        checks++;
        if (cycles !== N) begin
            errors++;
            $display("FAIL latency_pos: done after %0d cycles, required %0d", cycles, N);
        end
        checks++;
        if (bcnt !== N) begin
            errors++;
            $display("FAIL busy_len: busy %0d cycles, required %0d", bcnt, N);
        end
        checks++;
        if ({neg_zero, dout} !== e) begin
            errors++;
            $display("FAIL result_pos: nz/dout=%b/%h, required %b/%h", neg_zero, dout, e[N], e[N-1:0]);
        end
        $display("conv din=05 dout=%h nz=%b cycles=%0d", dout, neg_zero, cycles);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_values();
        logic [N-1:0] vals[6];
        int cycles, bcnt;
        logic [N:0] e;
        vals = '{8'h85, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h01};
        foreach (vals[k]) begin
            start_conv(vals[k], 1'b1);
            wait_done(cycles, bcnt);
            e = exp_q.pop_front();
            checks++;
            if (cycles >= 50) begin
                errors++;
                $display("FAIL timeout_val: no done for din=%h", vals[k]);
            end
            checks++;
            if ({neg_zero, dout} !== e) begin
                errors++;
                $display("FAIL result_val: din=%h nz/dout=%b/%h, required %b/%h",
                         vals[k], neg_zero, dout, e[N], e[N-1:0]);
            end
            $display("conv din=%h dout=%h nz=%b", vals[k], dout, neg_zero);
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        logic [N:0] e;
        logic [N-1:0] got;
        ndone = 0;
        got   = '0;
        start_conv(8'h85, 1'b1);
        for (int t = 0; t < 20; t++) begin
            if (t == 2) begin
                start = 1'b1;
                din   = 8'h33;
            end
            if (t == 4) start = 1'b0;
            if (done) begin
                ndone++;
                got = dout;
            end
            tick();
        end
        e = exp_q.pop_front();
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: %0d done pulses, required 1", ndone);
        end
        checks++;
        if (got !== e[N-1:0]) begin
            errors++;
            $display("FAIL ignore_result: dout=%h, required %h", got, e[N-1:0]);
        end
        $display("ignore_start din=85 dout=%h done_pulses=%0d", got, ndone);
    endtask

    task automatic test_reset_mid();
        int ndone, cycles, bcnt;
        logic [N:0] e;
        ndone = 0;
        start_conv(8'h05, 1'b0);
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1 || dout === '0) begin
            errors++;
            $display("FAIL pre_abort: busy=%b dout=%h, required busy=1 dout!=0", busy, dout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, neg_zero, dout} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b nz=%b dout=%h, required all 0",
                     busy, done, neg_zero, dout);
        end
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (done) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d done pulses, required 0", ndone);
        end
        start_conv(8'h81, 1'b1);
        wait_done(cycles, bcnt);
        e = exp_q.pop_front();
        checks++;
        if ({neg_zero, dout} !== e) begin
            errors++;
            $display("FAIL after_reset_conv: nz/dout=%b/%h, required %b/%h",
                     neg_zero, dout, e[N], e[N-1:0]);
        end
        $display("reset_mid: no_done=%0d then din=81 dout=%h", ndone, dout);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] vals[3];
        logic [N:0] e;
        logic [N-1:0] prev;
        int prev_cyc, cycles;
        vals     = '{8'h83, 8'h2A, 8'hC0};
        prev     = '0;
        prev_cyc = 0;
        start    = 1'b1;
        din      = vals[0];
        exp_q.push_back(model(vals[0]));
        tick();
        for (int k = 0; k < 3; k++) begin
            cycles = 0;
            while (!done && cycles < 50) begin
                if (k > 0) begin
                    checks++;
                    if (dout !== prev) begin
                        errors++;
                        $display("FAIL hold_dout: dout=%h, required %h", dout, prev);
                    end
                end
                tick();
                cycles++;
            end
            e = exp_q.pop_front();
            checks++;
            if ({neg_zero, dout} !== e) begin
                errors++;
                $display("FAIL b2b_result: k=%0d nz/dout=%b/%h, required %b/%h",
                         k, neg_zero, dout, e[N], e[N-1:0]);
            end
            if (k > 0) begin
                checks++;
                if (cyc - prev_cyc !== N + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing: %0d cycles, required %0d", cyc - prev_cyc, N + 2);
                end
            end
            $display("b2b k=%0d din=%h dout=%h at cycle %0d", k, vals[k], dout, cyc);
            prev     = dout;
            prev_cyc = cyc;
            if (k < 2) begin
                din = vals[k+1];
                exp_q.push_back(model(vals[k+1]));
            end else begin
                start = 1'b0;
            end
            tick();
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || dout !== prev) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b dout=%h, required 0 %h", busy, dout, prev);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        test_reset();
        test_positive();
        test_values();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
